pipelined_barrel_shifter: RTL

- Parametrised, pipelined multi-mode barrel shifter. Successor to the combinational single-mode SLL shifter.
- Supports SLL, SRL, SRA, ROL and ROR on a WIDTH-bit operand.
- Log-shift levels are split across STAGES register stages, with a valid/ready elastic handshake on both sides.
- Sits between the ALU issue logic and writeback. Used where shift timing must be cut, e.g. wide datapaths for the crane-game coprocessor.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 29 ++
 rtl/pipelined_barrel_shifter_if.sv | 30 +++
 rtl/pipelined_barrel_shifter_shift_stage.sv | 41 ++++
 rtl/pipelined_barrel_shifter.sv | 93 +++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and
// the mapping of log-shift levels onto pipeline stages.
package shifter_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] SHIFT_SLL = 3'd0;
  localparam logic [MODE_W-1:0] SHIFT_SRL = 3'd1;
  localparam logic [MODE_W-1:0] SHIFT_SRA = 3'd2;
  localparam logic [MODE_W-1:0] SHIFT_ROL = 3'd3;
  localparam logic [MODE_W-1:0] SHIFT_ROR = 3'd4;

  // Stage that performs shift level i (shift by 2**i).
  function automatic int stage_of_level(input int i, input int stages, input int shamt_w);
    return (i * stages) / shamt_w;
  endfunction

  // Lowest level handled by stage s; returns shamt_w when s is past the last stage,
  // so first_level(s+1) - first_level(s) is the level count of stage s.
  function automatic int first_level(input int s, input int stages, input int shamt_w);
    int r;
    r = shamt_w;
    for (int i = shamt_w - 1; i >= 0; i--) begin
      if (stage_of_level(i, stages, shamt_w) >= s) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Input/output handshake bundle of the pipelined barrel shifter.
interface pipelined_barrel_shifter_if import shifter_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [MODE_W-1:0]  in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  // Issue side: produces operations and consumes results.
  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// Combinational slice of the barrel shifter: applies a contiguous run of
// log-shift levels, lowest level first.
module shift_stage import shifter_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int FIRST_LEVEL = 0,
  parameter int LEVELS      = 1,
  localparam int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [MODE_W-1:0]  mode,
  output logic [WIDTH-1:0]   result
);

  // One fixed-distance step; reserved codes leave the data untouched.
  function automatic logic [WIDTH-1:0] apply_level(input logic [WIDTH-1:0] d,
                                                   input logic [MODE_W-1:0] m,
                                                   input int amt);
    case (m)
      SHIFT_SLL: return d << amt;
      SHIFT_SRL: return d >> amt;
      SHIFT_SRA: return $unsigned($signed(d) >>> amt);
      SHIFT_ROL: return (d << amt) | (d >> (WIDTH - amt));
      SHIFT_ROR: return (d >> amt) | (d << (WIDTH - amt));
      default:   return d;
    endcase
  endfunction

  // Walk every shamt bit; only the ones owned by this stage take effect.
  always_comb begin
    logic [WIDTH-1:0] acc;
    acc = operand;
    for (int l = 0; l < SHAMT_W; l++) begin
      if (l >= FIRST_LEVEL && l < FIRST_LEVEL + LEVELS && shamt[l]) begin
        acc = apply_level(acc, mode, 1 << l);
      end
    end
    result = acc;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter with an elastic valid/ready pipe.
// Each stage applies its share of shift levels before its register.
module pipelined_barrel_shifter import shifter_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic clock,
  input logic reset,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAST    = STAGES - 1;

  logic [STAGES-1:0]  valid_reg;
  logic [WIDTH-1:0]   data_reg  [STAGES];
  logic [SHAMT_W-1:0] shamt_reg [STAGES];
  logic [MODE_W-1:0]  mode_reg  [STAGES];
  logic [TAG_W-1:0]   tag_reg   [STAGES];

  logic [STAGES-1:0]  stage_valid;
  logic [WIDTH-1:0]   stage_data  [STAGES];
  logic [SHAMT_W-1:0] stage_shamt [STAGES];
  logic [MODE_W-1:0]  stage_mode  [STAGES];
  logic [TAG_W-1:0]   stage_tag   [STAGES];
  logic [WIDTH-1:0]   shifted     [STAGES];
  logic [STAGES-1:0]  advance;

  // A stage may load when it is empty or its occupant moves on (bubble collapse).
  always_comb begin
    advance = '0;
    advance[LAST] = !valid_reg[LAST] || bus.out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      advance[s] = !valid_reg[s] || advance[s + 1];
    end
  end

  assign bus.in_ready  = reset && advance[0];
  assign bus.out_valid = valid_reg[LAST];
  assign bus.out_data  = data_reg[LAST];
  assign bus.out_tag   = tag_reg[LAST];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_valid[gi] = bus.in_valid;
      assign stage_data[gi]  = bus.in_data;
      assign stage_shamt[gi] = bus.in_shamt;
      assign stage_mode[gi]  = bus.in_mode;
      assign stage_tag[gi]   = bus.in_tag;
    end else begin : g_body
      assign stage_valid[gi] = valid_reg[gi-1];
      assign stage_data[gi]  = data_reg[gi-1];
      assign stage_shamt[gi] = shamt_reg[gi-1];
      assign stage_mode[gi]  = mode_reg[gi-1];
      assign stage_tag[gi]   = tag_reg[gi-1];
    end

    shift_stage #(
      .WIDTH       (WIDTH),
      .FIRST_LEVEL (first_level(gi, STAGES, SHAMT_W)),
      .LEVELS      (first_level(gi + 1, STAGES, SHAMT_W) - first_level(gi, STAGES, SHAMT_W))
    ) u_shift (
      .operand (stage_data[gi]),
      .shamt   (stage_shamt[gi]),
      .mode    (stage_mode[gi]),
      .result  (shifted[gi])
    );
  end

  // Stage registers: cleared by reset, otherwise loaded whenever the stage advances.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_reg <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_reg[s]  <= '0;
        shamt_reg[s] <= '0;
        mode_reg[s]  <= '0;
        tag_reg[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (advance[s]) begin
          valid_reg[s] <= stage_valid[s];
          data_reg[s]  <= shifted[s];
          shamt_reg[s] <= stage_shamt[s];
          mode_reg[s]  <= stage_mode[s];
          tag_reg[s]   <= stage_tag[s];
        end
      end
    end
  end

endmodule
